// File: rtl/flow_ctrl_fsm.sv
// flow_ctrl_fsm: link flow-control sequencer for the four-lane datapath.
// It walks RESET -> INIT -> IDLE <-> ACTIVE and can enter a sticky ERROR state.
// Estado is read directly by the lane-change counter downstream.
// The FIFO almost-full and almost-empty thresholds are captured while in INIT.
//
// Ports:
//   clk            rising-edge system clock
//   rst            asynchronous, active-low reset
//   init           level-sensitive request to reconfigure
//   umbral_alto_in requested almost-full threshold
//   umbral_bajo_in requested almost-empty threshold
//   fifo_empty     per-lane FIFO empty flags
//   fifo_error     per-lane FIFO overflow/underflow pulses
//   Estado         encoded state (RESET=0, INIT=1, ACTIVE=2, ERROR=3, IDLE=4)
//   umbral_alto    latched almost-full threshold
//   umbral_bajo    latched almost-empty threshold
//   idle_out       state flag, high in IDLE
//   active_out     state flag, high in ACTIVE
//   error_out      state flag, high in ERROR
//   error_fifo     sticky OR of the lanes that have flagged an error
module flow_ctrl_fsm #(
  parameter int unsigned TH_W       = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            init,
  input  logic [TH_W-1:0] umbral_alto_in,
  input  logic [TH_W-1:0] umbral_bajo_in,
  input  logic [3:0]      fifo_empty,
  input  logic [3:0]      fifo_error,
  output logic [3:0]      Estado,
  output logic [TH_W-1:0] umbral_alto,
  output logic [TH_W-1:0] umbral_bajo,
  output logic            idle_out,
  output logic            active_out,
  output logic            error_out,
  output logic [3:0]      error_fifo
);

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_INIT   = 4'd1,
    S_ACTIVE = 4'd2,
    S_ERROR  = 4'd3,
    S_IDLE   = 4'd4
  } state_t;

  state_t            state_q, state_d;
  logic [TH_W-1:0]   alto_q, alto_d;
  logic [TH_W-1:0]   bajo_q, bajo_d;
  logic [3:0]        err_q, err_d;
  logic              idle_q, active_q, error_q;
  logic              thr_valid;
  logic              any_err;

  assign thr_valid = (umbral_bajo_in < umbral_alto_in) &&
                     (32'(umbral_alto_in) <= FIFO_DEPTH);
  assign any_err   = |fifo_error;

  always_comb begin
    state_d = state_q;
    alto_d  = alto_q;
    bajo_d  = bajo_q;
    err_d   = err_q;
    case (state_q)
      S_RESET: begin
        state_d = S_INIT;
        alto_d  = '0;
        bajo_d  = '0;
      end
      S_INIT: begin
        alto_d = umbral_alto_in;
        bajo_d = umbral_bajo_in;
        err_d  = err_q | fifo_error;
        if (any_err)                state_d = S_ERROR;
        else if (!init && thr_valid) state_d = S_IDLE;
      end
      S_IDLE: begin
        err_d = err_q | fifo_error;
        if (any_err)                state_d = S_ERROR;
        else if (init)              state_d = S_INIT;
        else if (fifo_empty != 4'hF) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        err_d = err_q | fifo_error;
        if (any_err)                state_d = S_ERROR;
        else if (init)              state_d = S_INIT;
        else if (fifo_empty == 4'hF) state_d = S_IDLE;
      end
      S_ERROR: begin
        err_d = err_q | fifo_error;
      end
      // A corrupted encoding is recovered through RESET.
      default: state_d = S_RESET;
    endcase
  end

  // The flags are decoded from state_d, so they switch on the same edge as Estado.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_RESET;
      alto_q   <= '0;
      bajo_q   <= '0;
      err_q    <= '0;
      idle_q   <= 1'b0;
      active_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      alto_q   <= alto_d;
      bajo_q   <= bajo_d;
      err_q    <= err_d;
      idle_q   <= (state_d == S_IDLE);
      active_q <= (state_d == S_ACTIVE);
      error_q  <= (state_d == S_ERROR);
    end
  end

  assign Estado      = state_q;
  assign umbral_alto = alto_q;
  assign umbral_bajo = bajo_q;
  assign idle_out    = idle_q;
  assign active_out  = active_q;
  assign error_out   = error_q;
  assign error_fifo  = err_q;

endmodule

// File: tb/tb_flow_ctrl_fsm.sv
module tb_flow_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       init;
  logic [3:0] alto_in, bajo_in, fifo_empty, fifo_error;
  logic [3:0] Estado, umbral_alto, umbral_bajo, error_fifo;
  logic       idle_out, active_out, error_out;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  flow_ctrl_fsm #(.TH_W(4), .FIFO_DEPTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .init           (init),
    .umbral_alto_in (alto_in),
    .umbral_bajo_in (bajo_in),
    .fifo_empty     (fifo_empty),
    .fifo_error     (fifo_error),
    .Estado         (Estado),
    .umbral_alto    (umbral_alto),
    .umbral_bajo    (umbral_bajo),
    .idle_out       (idle_out),
    .active_out     (active_out),
    .error_out      (error_out),
    .error_fifo     (error_fifo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       init;
    logic [3:0] alto, bajo, empty, ferr;
    logic [3:0] est, exp_alto, exp_bajo, exp_ef;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic i, logic [3:0] a, logic [3:0] b, logic [3:0] e,
                              logic [3:0] r, logic [3:0] st, logic [3:0] ea,
                              logic [3:0] eb, logic [3:0] ef);
    vec_t v;
    v.init = i; v.alto = a; v.bajo = b; v.empty = e; v.ferr = r;
    v.est = st; v.exp_alto = ea; v.exp_bajo = eb; v.exp_ef = ef;
    return v;
  endfunction

  task automatic check(input string name, input logic [3:0] est, input logic [3:0] ea,
                       input logic [3:0] eb, input logic [3:0] ef);
    logic ei, ea_f, ee;
    ei   = (est == 4'd4);
    ea_f = (est == 4'd2);
    ee   = (est == 4'd3);
    n_vec++;
    if (Estado !== est || umbral_alto !== ea || umbral_bajo !== eb ||
        error_fifo !== ef || idle_out !== ei || active_out !== ea_f || error_out !== ee) begin
      n_bad++;
      $display("FAIL %s: got Estado=%0d alto=%0d bajo=%0d efifo=%b i/a/e=%b%b%b, want Estado=%0d alto=%0d bajo=%0d efifo=%b i/a/e=%b%b%b",
               name, Estado, umbral_alto, umbral_bajo, error_fifo, idle_out, active_out,
               error_out, est, ea, eb, ef, ei, ea_f, ee);
    end
  endtask

  task automatic drive(input logic i, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] e, input logic [3:0] r);
    init = i; alto_in = a; bajo_in = b; fifo_empty = e; fifo_error = r;
  endtask

  initial begin
    //               init alto  bajo  empty  ferr   Estado alto bajo efifo
    vecs[0]  = mk(0, 6,  2, 4'hF, 4'h0, 1, 0, 0, 4'h0);  // RESET -> INIT
    vecs[1]  = mk(0, 6,  2, 4'hF, 4'h0, 4, 6, 2, 4'h0);  // INIT -> IDLE
    vecs[2]  = mk(1, 3,  5, 4'hF, 4'h0, 1, 6, 2, 4'h0);  // init from IDLE
    vecs[3]  = mk(0, 3,  5, 4'hF, 4'h0, 1, 3, 5, 4'h0);  // bajo > alto
    vecs[4]  = mk(0, 9,  2, 4'hF, 4'h0, 1, 9, 2, 4'h0);  // alto > depth
    vecs[5]  = mk(0, 5,  3, 4'hF, 4'h0, 4, 5, 3, 4'h0);
    vecs[6]  = mk(0, 5,  3, 4'hD, 4'h0, 2, 5, 3, 4'h0);  // traffic
    vecs[7]  = mk(0, 12, 0, 4'hD, 4'h0, 2, 5, 3, 4'h0);  // thresholds hold
    vecs[8]  = mk(0, 0,  9, 4'hF, 4'h0, 4, 5, 3, 4'h0);
    vecs[9]  = mk(0, 0,  9, 4'hE, 4'h0, 2, 5, 3, 4'h0);
    vecs[10] = mk(1, 7,  1, 4'hE, 4'h0, 1, 5, 3, 4'h0);  // reinit from ACTIVE
    vecs[11] = mk(0, 7,  1, 4'hF, 4'h0, 4, 7, 1, 4'h0);
    vecs[12] = mk(1, 4,  4, 4'hF, 4'h0, 1, 7, 1, 4'h0);
    vecs[13] = mk(0, 4,  4, 4'hF, 4'h0, 1, 4, 4, 4'h0);  // bajo == alto
    vecs[14] = mk(0, 8,  7, 4'hF, 4'h0, 4, 8, 7, 4'h0);  // alto == depth
    vecs[15] = mk(0, 8,  7, 4'hD, 4'h0, 2, 8, 7, 4'h0);
    vecs[16] = mk(1, 3,  1, 4'hD, 4'h4, 3, 8, 7, 4'h4);  // error beats init
    vecs[17] = mk(0, 3,  1, 4'hD, 4'h1, 3, 8, 7, 4'h5);  // accumulates
    vecs[18] = mk(1, 3,  1, 4'hF, 4'h0, 3, 8, 7, 4'h5);  // sticky
    vecs[19] = mk(0, 6,  2, 4'hF, 4'h0, 3, 8, 7, 4'h5);

    rst = 1'b0;
    drive(0, 0, 0, 4'hF, 4'h0);
    repeat (3) @(posedge clk);
    #1 check("reset_state", 0, 0, 0, 4'h0);

    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].init, vecs[i].alto, vecs[i].bajo, vecs[i].empty, vecs[i].ferr);
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), vecs[i].est, vecs[i].exp_alto, vecs[i].exp_bajo,
               vecs[i].exp_ef);
      @(negedge clk);
    end

    // Asynchronous reset between edges while in ERROR.
    #2 rst = 1'b0;
    #1 check("async_reset", 0, 0, 0, 4'h0);

    // An error seen in RESET is ignored; one seen in INIT is taken.
    @(negedge clk);
    rst = 1'b1;
    drive(0, 6, 2, 4'hF, 4'hF);
    @(posedge clk);
    #1 check("err_in_reset", 1, 0, 0, 4'h0);
    @(negedge clk);
    drive(0, 6, 2, 4'hF, 4'h2);
    @(posedge clk);
    #1 check("err_in_init", 3, 6, 2, 4'h2);

    // An error in IDLE takes priority over a drop in the empty flags.
    @(negedge clk);
    rst = 1'b0;
    #1 check("reset_again", 0, 0, 0, 4'h0);
    rst = 1'b1;
    drive(0, 6, 2, 4'hF, 4'h0);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 check("idle_again", 4, 6, 2, 4'h0);
    @(negedge clk);
    drive(0, 6, 2, 4'h0, 4'h8);
    @(posedge clk);
    #1 check("err_in_idle", 3, 6, 2, 4'h8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
